// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Multi-cycle unsigned restoring divider. Each quotient bit
//               takes one SHIFT cycle and one SUB cycle. Divide-by-zero
//               returns all-ones quotient and the dividend as remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Counter is one bit wider than needed so it never wraps mid-operation.
    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_SUB   = 2'd3
    } state_t;

    state_t             r_ps;
    state_t             w_ns;
    logic [WIDTH:0]     r_a;      // partial remainder, one guard bit
    logic [WIDTH-1:0]   r_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_m;      // captured divisor
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH:0]     w_m_ext;
    logic               w_ge;
    logic [WIDTH:0]     w_diff;

    assign w_m_ext = {1'b0, r_m};
    assign w_ge    = (r_a >= w_m_ext);
    assign w_diff  = r_a - w_m_ext;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps <= S_IDLE;
        end else begin
            r_ps <= w_ns;
        end
    end

    // Next-state logic.
    always_comb begin
        w_ns = r_ps;
        case (r_ps)
            S_IDLE:  if (start) w_ns = S_LOAD;
            S_LOAD:  if (!start) w_ns = (r_m != '0) ? S_SHIFT : S_IDLE;
            S_SHIFT: w_ns = S_SUB;
            S_SUB:   w_ns = (r_cnt == c_last) ? S_IDLE : S_SHIFT;
            default: w_ns = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift/restore-subtract, completion flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_ps)
                S_IDLE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_m   <= divisor;
                        r_a   <= '0;
                        r_cnt <= '0;
                        r_dbz <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Zero divisor: r_q still holds the captured dividend.
                    if (!start && (r_m == '0)) begin
                        r_dbz  <= 1'b1;
                        r_a    <= {1'b0, r_q};
                        r_q    <= '1;
                        r_done <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
                end
                S_SUB: begin
                    if (w_ge) begin
                        r_a    <= w_diff;
                        r_q[0] <= 1'b1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_a[WIDTH-1:0];
    assign ready       = (r_ps == S_IDLE);
    assign busy        = (r_ps != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; level-sampled on clk.
REQ-005 dividend  input  WIDTH  unsigned numerator.
REQ-006 divisor  input  WIDTH  unsigned denominator.
REQ-007 quotient  output  WIDTH  unsigned result; registered.
REQ-008 remainder  output  WIDTH  unsigned result; registered.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on completion; registered.
REQ-012 div_by_zero  output  1  error flag for the last accepted operation; registered.

Function
REQ-013 FSM states: IDLE, LOAD, SHIFT, SUB; 2-bit encoding; unreachable codes SHALL go to IDLE.
REQ-014 IDLE -> LOAD when start=1, else stay in IDLE.
REQ-015 On the IDLE->LOAD edge: capture Q<=dividend, M<=divisor, A<=0, cnt<=0, clear div_by_zero.
REQ-016 Operand inputs SHALL be ignored in every other cycle.
REQ-017 LOAD holds while start=1.
REQ-018 LOAD with start=0: go to SHIFT if M!=0; otherwise go to IDLE with div_by_zero<=1, Q<=all ones, A<=captured dividend.
REQ-019 SHIFT: {A,Q} <= {A,Q} shifted left by 1, zero into Q[0]; next state SUB.
REQ-020 A SHALL be WIDTH+1 bits wide so that the shifted partial remainder cannot overflow.
REQ-021 SUB: if A >= {0,M}, then A <= A-M and Q[0] <= 1; otherwise A and Q are unchanged (restoring).
REQ-022 SUB also performs cnt <= cnt+1.
REQ-023 SUB exit: go to IDLE when cnt == WIDTH-1 before the increment, else go to SHIFT.
REQ-024 cnt SHALL be ceil(log2(WIDTH))+1 bits and SHALL not wrap within an operation.
REQ-025 Latency: exactly 2*WIDTH clock edges from leaving LOAD to entering IDLE (16 for WIDTH=8).
REQ-026 Divide by zero: 1 edge from leaving LOAD to entering IDLE.
REQ-027 Output mapping: quotient = Q; remainder = A[WIDTH-1:0].
REQ-028 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor whenever divisor != 0.
REQ-029 Results SHALL hold stable in IDLE until the next accepted start.
REQ-030 done SHALL be high for exactly one cycle, the first IDLE cycle after a normal or divide-by-zero completion, and low otherwise.
REQ-031 start asserted during SHIFT/SUB SHALL be ignored; no restart and no effect on results.
REQ-032 start=1 in the first IDLE cycle after completion SHALL be accepted; done still pulses in that cycle.
REQ-033 Back-to-back operations need no idle gap beyond that one IDLE cycle.

Reset
REQ-034 rst=0 SHALL force, immediately and regardless of clk: ps=IDLE; A, Q, M, cnt = 0; quotient=0; remainder=0; done=0; div_by_zero=0; ready=1; busy=0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-036 After rst releases, the block SHALL accept start on the next rising edge.

Verification (WIDTH=8)
REQ-037 Basic division: dividend=100, divisor=7, start one cycle -> 16 edges after leaving LOAD, quotient=14, remainder=2, done pulses once, ready=1.
REQ-038 Divide by zero: dividend=55, divisor=0 -> 1 edge after leaving LOAD, quotient=255, remainder=55, div_by_zero=1, done pulses; the next valid operation clears div_by_zero.
REQ-039 Edge values: 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 200/200 -> q=1, r=0; 255/255 -> q=1, r=0.
REQ-040 Held start with operand change: start held 3 cycles with operands changed after the first cycle -> the result uses the first-cycle operands; the FSM stays in LOAD until start falls.
REQ-041 Reset mid-operation: rst=0 during SUB of 100/7 -> all outputs at reset values immediately, no done pulse; a following 9/2 gives q=4, r=1.
REQ-042 Random check: 1000 random operand pairs, including back-to-back starts in the done cycle -> every result matches dividend/divisor and dividend%divisor, and latency always equals 16.
